dmem_access_unit: RTL and testbench
===================================

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10: the number of word-index bits driven to the RAM.
REQ-002 The module SHALL have port clock, input, 1 bit: the master clock; all state updates on the rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port req_valid, input, 1 bit: the processor memory-stage request is present.
REQ-005 The module SHALL have port req_addr, input, 32 bits: byte address (processor address_dmem).
REQ-006 The module SHALL have port req_wdata, input, 32 bits: store data, right-aligned (processor data).
REQ-007 The module SHALL have port req_wren, input, 1 bit: 1 = store, 0 = load.
REQ-008 The module SHALL have port req_access_type, input, 3 bits: funct3; 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 The module SHALL have port req_ready, output, 1 bit: a request is accepted in a cycle with req_valid and req_ready both high.
REQ-010 The module SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-011 The module SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-012 The module SHALL have port rsp_error, output, 1 bit: the completed request was misaligned or illegal; valid with rsp_valid.
REQ-013 The module SHALL have port ram_addr, output, ADDR_WIDTH bits: word index equal to addr[ADDR_WIDTH+1:2].
REQ-014 The module SHALL have port ram_wdata, output, 32 bits: full-word write data.
REQ-015 The module SHALL have port ram_wren, output, 1 bit: word write enable.
REQ-016 The module SHALL have port ram_q, input, 32 bits: synchronous RAM read data, valid one cycle after the address.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD_RSP, STORE_RSP and RMW_WRITE; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, ram_addr SHALL be driven combinationally from req_addr; in all other states it SHALL come from the captured address.
REQ-019 On acceptance, the module SHALL register the address, data, access type and direction.
REQ-020 Load accepted at cycle T: the module SHALL issue the RAM read at T, go to LOAD_RSP, and assert rsp_valid at T+1 with data taken from ram_q.
REQ-021 Load extraction: the module SHALL select the byte using addr[1:0] and the half using addr[1].
REQ-022 Load extension: B and H SHALL be sign-extended; BU and HU SHALL be zero-extended.
REQ-023 SW accepted at T: the module SHALL assert ram_wren at T with ram_wdata equal to req_wdata, go to STORE_RSP, and assert rsp_valid at T+1.
REQ-024 SB or SH accepted at T: the module SHALL issue a read at T and go to RMW_WRITE.
REQ-025 In RMW_WRITE at T+1, the module SHALL merge req_wdata[7:0] or [15:0] into ram_q at the lane selected by addr[1:0], assert ram_wren, and go to STORE_RSP.
REQ-026 For SB or SH, rsp_valid SHALL be asserted at T+2.
REQ-027 Errors: H or HU with addr[0]=1, W with addr[1:0]≠0, a store with type 100 or 101, and any type 011, 110 or 111 SHALL cause no RAM write.
REQ-028 An error request SHALL go to LOAD_RSP or STORE_RSP and produce rsp_valid at T+1 with rsp_error=1 and rsp_rdata=0.
REQ-029 Address bits above ADDR_WIDTH+1 SHALL be ignored, so addresses wrap modulo 2^(ADDR_WIDTH+2).
REQ-030 ram_wren SHALL never be asserted in LOAD_RSP or STORE_RSP.
REQ-031 req_valid while not ready SHALL be ignored, with no queuing.
REQ-032 Both response states SHALL return to IDLE after one cycle, so sustained throughput is one request per 2 cycles (3 for SB/SH).

Reset
REQ-033 Asserting reset low SHALL immediately force state IDLE, rsp_valid=0, rsp_error=0, rsp_rdata=0, and all captured registers to 0.
REQ-034 ram_wren SHALL be 0 while reset is low.
REQ-035 Reset asserted while in RMW_WRITE SHALL suppress the pending write.
REQ-036 After reset releases, req_ready SHALL be 1 in the first cycle.

Structure
REQ-037 A shared package SHALL hold the access-type encodings (ACC_B, ACC_H, ACC_W, ACC_BU, ACC_HU), the FSM state enum and the store opcode constant 7'b0100011.
REQ-038 A combinational sub-module lane_extract SHALL perform load byte/half selection plus extension, and store lane merge.
REQ-039 All sequential logic SHALL reside in dmem_access_unit.

Verification
REQ-040 Bench: SW addr 0x10 data 0x8899AABB, then LW addr 0x10 -> rsp_rdata 0x8899AABB at T+1, rsp_error=0.
REQ-041 Bench: word 0x8899AABB at addr 0x10; LB addr 0x11 -> 0xFFFFFFAA; LBU addr 0x11 -> 0x000000AA; LH addr 0x12 -> 0xFFFF8899; LHU addr 0x12 -> 0x00008899.
REQ-042 Bench: SB addr 0x13 data 0x12 -> exactly one ram_wren at T+1 with 0x1299AABB, rsp_valid at T+2, then LW -> 0x1299AABB.
REQ-043 Bench: LW addr 0x12, SH addr 0x11, SB with type 100 -> each rsp_error=1, rsp_rdata=0 at T+1, no ram_wren, memory unchanged.
REQ-044 Bench: reset low during RMW_WRITE of SH addr 0x20 -> no write, rsp_valid=0, req_ready=1 after release, word at 0x20 unchanged.
REQ-045 Bench: back-to-back req_valid held high for 4 LWs -> accepted on alternate cycles only, 4 rsp_valid pulses, and addr 0x1010 with ADDR_WIDTH=10 aliases word 4 (addr 0x10).

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: funct3 access encodings,
// the FSM state type, the store opcode and the legality check for a request.
package dmem_access_unit_pkg;

    localparam logic [2:0] ACC_B  = 3'b000;
    localparam logic [2:0] ACC_H  = 3'b001;
    localparam logic [2:0] ACC_W  = 3'b010;
    localparam logic [2:0] ACC_BU = 3'b100;
    localparam logic [2:0] ACC_HU = 3'b101;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_RSP,
        STORE_RSP,
        RMW_WRITE
    } state_e;

    // Misaligned halves/words, unsigned stores and unused funct3 codes are rejected.
    function automatic logic access_error(input logic [1:0] lane,
                                          input logic [2:0] acc_type,
                                          input logic       is_store);
        case (acc_type)
            ACC_B:   access_error = 1'b0;
            ACC_H:   access_error = lane[0];
            ACC_W:   access_error = (lane != 2'b00);
            ACC_BU:  access_error = is_store;
            ACC_HU:  access_error = is_store || lane[0];
            default: access_error = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_lane_extract.sv
// Combinational lane logic: picks and extends the byte/half of a loaded word,
// and merges a byte/half store into an existing word.
module lane_extract
    import dmem_access_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  acc_type_i,
    input  logic [15:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (lane_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

        load_data_o = word_i;
        case (acc_type_i)
            ACC_B:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            ACC_BU:  load_data_o = {24'h000000, byte_sel};
            ACC_H:   load_data_o = {{16{half_sel[15]}}, half_sel};
            ACC_HU:  load_data_o = {16'h0000, half_sel};
            default: load_data_o = word_i;
        endcase
    end

    // acc_type_i[0] distinguishes SH from SB; only those two reach the merge path.
    always_comb begin
        merged_o = word_i;
        if (acc_type_i[0]) begin
            if (lane_i[1]) merged_o[31:16] = store_data_i;
            else           merged_o[15:0]  = store_data_i;
        end else begin
            case (lane_i)
                2'd0: merged_o[7:0]   = store_data_i[7:0];
                2'd1: merged_o[15:8]  = store_data_i[7:0];
                2'd2: merged_o[23:16] = store_data_i[7:0];
                2'd3: merged_o[31:24] = store_data_i[7:0];
                default: merged_o = word_i;
            endcase
        end
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns processor byte/half/word loads and stores into
// word accesses on a synchronous RAM, using read-modify-write for SB/SH.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    input  logic                  req_wren,
    input  logic [2:0]            req_access_type,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_wren,
    input  logic [31:0]           ram_q
);

    localparam int AW2 = ADDR_WIDTH + 2;

    state_e          state_q, state_d;
    logic [AW2-1:0]  addr_q;
    logic [15:0]     wdata_q;
    logic [2:0]      type_q;
    logic            wren_q;
    logic            err_q;

    logic            accept;
    logic            req_err;
    logic            wr_en;
    logic [31:0]     load_data;
    logic [31:0]     merged;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:AW2];

    assign accept  = req_valid && (state_q == IDLE);
    assign req_err = access_error(req_addr[1:0], req_access_type, req_wren);

    lane_extract u_lane_extract (
        .word_i       (ram_q),
        .lane_i       (addr_q[1:0]),
        .acc_type_i   (type_q),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .merged_o     (merged)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            wren_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr[AW2-1:0];
                wdata_q <= req_wdata[15:0];
                type_q  <= req_access_type;
                wren_q  <= req_wren;
                err_q   <= req_err;
            end
        end
    end

    // In IDLE the RAM sees the live request so reads and word writes start at once.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        rsp_rdata = 32'h0;
        ram_addr  = addr_q[AW2-1:2];
        ram_wdata = req_wdata;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                ram_addr  = req_addr[AW2-1:2];
                if (req_valid) begin
                    if (req_err) begin
                        state_d = req_wren ? STORE_RSP : LOAD_RSP;
                    end else if (!req_wren) begin
                        state_d = LOAD_RSP;
                    end else if (req_access_type == ACC_W) begin
                        wr_en   = 1'b1;
                        state_d = STORE_RSP;
                    end else begin
                        state_d = RMW_WRITE;
                    end
                end
            end
            LOAD_RSP: begin
                rsp_valid = 1'b1;
                rsp_error = err_q;
                rsp_rdata = (err_q || wren_q) ? 32'h0 : load_data;
                state_d   = IDLE;
            end
            STORE_RSP: begin
                rsp_valid = 1'b1;
                rsp_error = err_q;
                state_d   = IDLE;
            end
            RMW_WRITE: begin
                wr_en     = 1'b1;
                ram_wdata = merged;
                state_d   = STORE_RSP;
            end
            default: state_d = IDLE;
        endcase
        ram_wren = wr_en && reset;
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: a bench-side RAM, a transaction-level reference
// model with a per-cycle scoreboard, directed literal cases and random traffic.
module tb_dmem_access_unit;

    localparam int AW = 10;

    typedef struct {
        logic [AW-1:0] idx;
        logic [31:0]   data;
        bit            hasLit;
        logic [31:0]   lit;
    } wr_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        bit          hasLit;
        logic [31:0] lit;
    } rsp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          req_wren = 1'b0;
    logic [2:0]    req_access_type = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_wren;
    logic [31:0]   ram_q = '0;

    logic [31:0] mem    [0:(1<<AW)-1] = '{default: 32'h0};
    logic [31:0] refMem [0:(1<<AW)-1] = '{default: 32'h0};

    wr_t  expWr  [int];
    rsp_t expRsp [int];

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  checkEn = 1'b0;

    dmem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_wren        (req_wren),
        .req_access_type (req_access_type),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_error       (rsp_error),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_wren        (ram_wren),
        .ram_q           (ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cyc, actual, expected);
        end
    endtask

    // Reference rules written as plain arithmetic on the addressed word.
    function automatic bit modelErr(input logic [1:0] lo, input logic [2:0] t, input logic w);
        bit e;
        case (t)
            3'b000:  e = 0;
            3'b001:  e = lo[0];
            3'b010:  e = (lo != 0);
            3'b100:  e = w;
            3'b101:  e = w || lo[0];
            default: e = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] lo, input logic [2:0] t);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = word >> (8 * lo);
        b  = sh[7:0];
        h  = sh[15:0];
        case (t)
            3'b000:  return 32'($signed(b));
            3'b100:  return {24'h0, b};
            3'b001:  return 32'($signed(h));
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] modelMerge(input logic [31:0] word, input logic [31:0] d, input logic [1:0] lo, input logic [2:0] t);
        logic [31:0] mask;
        mask = (t == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (word & ~(mask << (8 * lo))) | ((d & mask) << (8 * lo));
    endfunction

    // Scoreboard: every cycle, writes and responses must match exactly what was scheduled.
    always @(negedge clock) begin
        if (checkEn) begin
            if (expWr.exists(cyc)) begin
                checkOutput("wrEnable", {31'h0, ram_wren}, 32'h1);
                checkOutput("wrAddr", {22'h0, ram_addr}, {22'h0, expWr[cyc].idx});
                checkOutput("wrData", ram_wdata, expWr[cyc].data);
                if (expWr[cyc].hasLit) checkOutput("wrDataLit", ram_wdata, expWr[cyc].lit);
                expWr.delete(cyc);
            end else begin
                checkOutput("noWrite", {31'h0, ram_wren}, 32'h0);
            end
            if (expRsp.exists(cyc)) begin
                checkOutput("rspValid", {31'h0, rsp_valid}, 32'h1);
                checkOutput("rspError", {31'h0, rsp_error}, {31'h0, expRsp[cyc].err});
                checkOutput("rspRdata", rsp_rdata, expRsp[cyc].rdata);
                if (expRsp[cyc].hasLit) checkOutput("rspRdataLit", rsp_rdata, expRsp[cyc].lit);
                expRsp.delete(cyc);
            end else begin
                checkOutput("noRsp", {31'h0, rsp_valid}, 32'h0);
            end
        end
    end

    // Called just after a rising edge; returns the acceptance cycle in n.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w,
                                 input logic [2:0] t, input bit hasLit, input logic [31:0] lit,
                                 input bit hold, output int n);
        int waits;
        logic [AW-1:0] idx;
        logic [1:0] lo;
        bit e;
        waits = 0;
        while (!req_ready && waits < 10) begin
            @(posedge clock); #1;
            waits++;
        end
        if (!req_ready) begin
            errors++;
            $display("[TB] FAIL readyTimeout at cycle %0d: got ready 0 want 1", cyc);
        end
        req_valid = 1'b1;
        req_addr = a;
        req_wdata = d;
        req_wren = w;
        req_access_type = t;
        n = cyc;
        idx = a[AW+1:2];
        lo = a[1:0];
        e = modelErr(lo, t, w);
        if (e) begin
            expRsp[n+1] = '{1'b1, 32'h0, hasLit, lit};
        end else if (!w) begin
            expRsp[n+1] = '{1'b0, modelLoad(refMem[idx], lo, t), hasLit, lit};
        end else if (t == 3'b010) begin
            refMem[idx] = d;
            expWr[n] = '{idx, d, hasLit, lit};
            expRsp[n+1] = '{1'b0, 32'h0, 1'b0, 32'h0};
        end else begin
            refMem[idx] = modelMerge(refMem[idx], d, lo, t);
            expWr[n+1] = '{idx, refMem[idx], hasLit, lit};
            expRsp[n+2] = '{1'b0, 32'h0, 1'b0, 32'h0};
        end
        @(posedge clock); #1;
        if (!hold) req_valid = 1'b0;
        checkOutput("busyAfterAccept", {31'h0, req_ready}, 32'h0);
    endtask

    initial begin
        int n;
        int diffs;
        logic [31:0] oldWord;

        // Reset held with a legal SW presented: nothing may reach the RAM.
        req_valid = 1'b1;
        req_addr = 32'h10;
        req_wdata = 32'hDEADBEEF;
        req_wren = 1'b1;
        req_access_type = 3'b010;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("resetReady", {31'h0, req_ready}, 32'h1);
        checkOutput("resetRspValid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("resetRspError", {31'h0, rsp_error}, 32'h0);
        checkOutput("resetRdata", rsp_rdata, 32'h0);
        checkOutput("resetWren", {31'h0, ram_wren}, 32'h0);
        req_valid = 1'b0;
        reset = 1'b1;
        checkOutput("readyAfterRelease", {31'h0, req_ready}, 32'h1);
        checkEn = 1'b1;

        applyStimulus(32'h10, 32'h8899AABB, 1, 3'b010, 1, 32'h8899AABB, 0, n);
        applyStimulus(32'h10, 32'h0, 0, 3'b010, 1, 32'h8899AABB, 0, n);
        applyStimulus(32'h11, 32'h0, 0, 3'b000, 1, 32'hFFFFFFAA, 0, n);
        applyStimulus(32'h11, 32'h0, 0, 3'b100, 1, 32'h000000AA, 0, n);
        applyStimulus(32'h12, 32'h0, 0, 3'b001, 1, 32'hFFFF8899, 0, n);
        applyStimulus(32'h12, 32'h0, 0, 3'b101, 1, 32'h00008899, 0, n);
        applyStimulus(32'h13, 32'h12, 1, 3'b000, 1, 32'h1299AABB, 0, n);
        applyStimulus(32'h10, 32'h0, 0, 3'b010, 1, 32'h1299AABB, 0, n);

        applyStimulus(32'h12, 32'h0, 0, 3'b010, 1, 32'h0, 0, n);
        applyStimulus(32'h11, 32'h5555, 1, 3'b001, 1, 32'h0, 0, n);
        applyStimulus(32'h10, 32'h77, 1, 3'b100, 1, 32'h0, 0, n);
        applyStimulus(32'h10, 32'h0, 0, 3'b010, 1, 32'h1299AABB, 0, n);

        // Reset dropped while the SH sits in its merge cycle: the write must vanish.
        applyStimulus(32'h20, 32'hCAFEF00D, 1, 3'b010, 0, 32'h0, 0, n);
        oldWord = refMem[8];
        applyStimulus(32'h20, 32'h1234, 1, 3'b001, 0, 32'h0, 0, n);
        reset = 1'b0;
        expWr.delete(n + 1);
        expRsp.delete(n + 2);
        refMem[8] = oldWord;
        #2;
        checkOutput("rmwResetRspValid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("rmwResetRdata", rsp_rdata, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        checkOutput("rmwResetReady", {31'h0, req_ready}, 32'h1);
        applyStimulus(32'h20, 32'h0, 0, 3'b010, 1, 32'hCAFEF00D, 0, n);

        // Valid held high across four loads; 0x1010 aliases word 4.
        applyStimulus(32'h1010, 32'h0, 0, 3'b010, 1, 32'h1299AABB, 1, n);
        applyStimulus(32'h20, 32'h0, 0, 3'b010, 1, 32'hCAFEF00D, 1, n);
        applyStimulus(32'h10, 32'h0, 0, 3'b010, 1, 32'h1299AABB, 1, n);
        applyStimulus(32'h1010, 32'h0, 0, 3'b010, 1, 32'h1299AABB, 0, n);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            bit hold;
            a = $urandom & 32'hFFFF_F03F;
            hold = ($urandom_range(0, 3) == 0);
            applyStimulus(a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0, 32'h0, hold, n);
            if (!hold && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clock);
                #1;
            end
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checkEn = 1'b0;

        checkOutput("pendingExpectations", 32'(expWr.size() + expRsp.size()), 32'h0);
        diffs = 0;
        for (int k = 0; k < (1 << AW); k++) if (mem[k] !== refMem[k]) diffs++;
        checkOutput("memoryImageDiffs", 32'(diffs), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
